// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arbiter
//  Purpose  : Two-port arbiter in front of a single SDRAM controller.
//             Port A is an 8-bit CPU port, port B is a 16-bit DMA/loader
//             port. Each access is one strobe pulse (sd_we or sd_rd) held
//             until the controller reports sd_ready.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, init_n              : clock, asynchronous active-low reset
//    a_req/a_we/a_addr/a_din  : port A request (8-bit data)
//    a_dout/a_ack             : port A read data, one-cycle completion pulse
//    b_req/b_we/b_addr/b_din  : port B request (16-bit data)
//    b_wtbt                   : port B byte enables for writes
//    b_dout/b_ack             : port B read data, one-cycle completion pulse
//    sd_addr/sd_din/sd_wtbt   : registered command to the controller
//    sd_we/sd_rd              : write / read strobes
//    sd_dout/sd_ready         : controller read data and ready flag
//  Parameters
//    A_PRIORITY               : 1 = A wins ties, 0 = round-robin on ties
// ============================================================================
module sdram_arbiter #(
  parameter int A_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [24:0] a_addr,
  input  logic [7:0]  a_din,
  output logic [7:0]  a_dout,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [24:0] b_addr,
  input  logic [15:0] b_din,
  input  logic [1:0]  b_wtbt,
  output logic [15:0] b_dout,
  output logic        b_ack,
  output logic [24:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_wtbt,
  output logic        sd_we,
  output logic        sd_rd,
  input  logic [15:0] sd_dout,
  input  logic        sd_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_start;
  logic        w_pick_b;
  logic        w_done;
  logic        r_grant_b;
  logic        r_last_b;
  logic [24:0] r_sd_addr;
  logic [15:0] r_sd_din;
  logic [1:0]  r_sd_wtbt;
  logic        r_sd_we;
  logic        r_sd_rd;
  logic        r_a_ack;
  logic        r_b_ack;
  logic [7:0]  r_a_dout;
  logic [15:0] r_b_dout;
  logic [1:0]  w_b_wtbt;
  logic        w_unused_b_addr0;

  // Port B is word addressed; its LSB is forced to zero on the bus.
  assign w_unused_b_addr0 = b_addr[0];

  // A write with no byte enables means a full-word write; reads are always
  // full-word.
  assign w_b_wtbt = !b_we ? 2'b11 : ((b_wtbt == 2'b00) ? 2'b11 : b_wtbt);

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    // Tie-break: fixed A-first, or the port not granted last.
    if (a_req && b_req)
      w_pick_b = (A_PRIORITY != 0) ? 1'b0 : !r_last_b;
    else
      w_pick_b = b_req;
    case (r_state)
      S_IDLE: begin
        // The ack cycle is skipped so the requester can drop its request
        // and so the strobe stays low for a full cycle between accesses.
        if (sd_ready && !r_a_ack && !r_b_ack && (a_req || b_req)) begin
          w_start      = 1'b1;
          w_next_state = S_GUARD;
        end
      end
      // The controller samples the strobe one cycle late, so sd_ready is
      // still stale here.
      S_GUARD: w_next_state = S_WAIT;
      S_WAIT: begin
        if (sd_ready) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_grant_b <= 1'b0;
      r_last_b  <= 1'b1;
      r_sd_addr <= '0;
      r_sd_din  <= '0;
      r_sd_wtbt <= '0;
      r_sd_we   <= 1'b0;
      r_sd_rd   <= 1'b0;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_dout  <= '0;
      r_b_dout  <= '0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      if (w_start) begin
        r_grant_b <= w_pick_b;
        r_last_b  <= w_pick_b;
        if (w_pick_b) begin
          r_sd_addr <= {b_addr[24:1], 1'b0};
          r_sd_din  <= b_din;
          r_sd_wtbt <= w_b_wtbt;
          r_sd_we   <= b_we;
          r_sd_rd   <= !b_we;
        end else begin
          r_sd_addr <= a_addr;
          r_sd_din  <= {a_din, a_din};
          r_sd_wtbt <= 2'b00;
          r_sd_we   <= a_we;
          r_sd_rd   <= !a_we;
        end
      end
      if (w_done) begin
        r_sd_we <= 1'b0;
        r_sd_rd <= 1'b0;
        if (r_grant_b) begin
          r_b_ack <= 1'b1;
          if (r_sd_rd) r_b_dout <= sd_dout;
        end else begin
          r_a_ack <= 1'b1;
          if (r_sd_rd) r_a_dout <= sd_dout[7:0];
        end
      end
    end
  end

  assign sd_addr = r_sd_addr;
  assign sd_din  = r_sd_din;
  assign sd_wtbt = r_sd_wtbt;
  assign sd_we   = r_sd_we;
  assign sd_rd   = r_sd_rd;
  assign a_ack   = r_a_ack;
  assign b_ack   = r_b_ack;
  assign a_dout  = r_a_dout;
  assign b_dout  = r_b_dout;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_arbiter
//  Purpose  : Directed self-checking bench for sdram_arbiter. A small
//             controller model answers the strobes with a programmable
//             number of sd_ready-low cycles; a second instance with
//             round-robin arbitration shares all inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

  logic        clk;
  logic        init_n;
  logic        a_req, a_we;
  logic [24:0] a_addr;
  logic [7:0]  a_din;
  logic [7:0]  a_dout;
  logic        a_ack;
  logic        b_req, b_we;
  logic [24:0] b_addr;
  logic [15:0] b_din;
  logic [1:0]  b_wtbt;
  logic [15:0] b_dout;
  logic        b_ack;
  logic [24:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_wtbt;
  logic        sd_we, sd_rd;
  logic [15:0] sd_dout;
  logic        sd_ready;

  logic        rr_a_ack, rr_b_ack;
  logic [7:0]  rr_unused_adout;
  logic [15:0] rr_unused_bdout;
  logic [24:0] rr_unused_addr;
  logic [15:0] rr_unused_din;
  logic [1:0]  rr_unused_wtbt;
  logic        rr_unused_we, rr_unused_rd;

  sdram_arbiter #(.A_PRIORITY(1)) u_dut (
    .clk(clk), .init_n(init_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_wtbt(b_wtbt), .b_dout(b_dout), .b_ack(b_ack),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_wtbt(sd_wtbt),
    .sd_we(sd_we), .sd_rd(sd_rd), .sd_dout(sd_dout), .sd_ready(sd_ready)
  );

  sdram_arbiter #(.A_PRIORITY(0)) u_dut_rr (
    .clk(clk), .init_n(init_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .a_dout(rr_unused_adout), .a_ack(rr_a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .b_wtbt(b_wtbt), .b_dout(rr_unused_bdout), .b_ack(rr_b_ack),
    .sd_addr(rr_unused_addr), .sd_din(rr_unused_din), .sd_wtbt(rr_unused_wtbt),
    .sd_we(rr_unused_we), .sd_rd(rr_unused_rd), .sd_dout(sd_dout),
    .sd_ready(sd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- controller model ----------------
  logic [15:0] mem [0:1023];
  logic        m_clear;
  int          m_wait;
  int          m_cnt;
  logic        m_prev;
  logic [24:0] m_addr;
  logic [15:0] m_din;
  logic [1:0]  m_wtbt;
  logic        m_we;

  function automatic logic [15:0] rd_data(input logic [15:0] w, input logic [1:0] wt,
                                          input logic a0);
    if (wt == 2'b00) return {8'h00, (a0 ? w[15:8] : w[7:0])};
    return w;
  endfunction

  function automatic logic [15:0] wr_merge(input logic [15:0] w, input logic [15:0] d,
                                           input logic [1:0] wt, input logic a0);
    case (wt)
      2'b00:   return a0 ? {d[15:8], w[7:0]} : {w[15:8], d[7:0]};
      2'b01:   return {w[15:8], d[7:0]};
      2'b10:   return {d[15:8], w[7:0]};
      default: return d;
    endcase
  endfunction

  always @(posedge clk or negedge init_n) begin
    if (m_clear)
      for (int k = 0; k < 1024; k++) mem[k] <= 16'h0000;
    if (!init_n) begin
      sd_ready <= 1'b1;
      sd_dout  <= 16'h0000;
      m_cnt    <= 0;
      m_prev   <= 1'b0;
    end else begin
      m_prev <= sd_we | sd_rd;
      if ((sd_we | sd_rd) && !m_prev) begin
        m_addr <= sd_addr; m_din <= sd_din; m_wtbt <= sd_wtbt; m_we <= sd_we;
        if (m_wait == 0) begin
          if (sd_we) mem[sd_addr[10:1]] <= wr_merge(mem[sd_addr[10:1]], sd_din, sd_wtbt, sd_addr[0]);
          else       sd_dout <= rd_data(mem[sd_addr[10:1]], sd_wtbt, sd_addr[0]);
        end else begin
          sd_ready <= 1'b0;
          m_cnt    <= m_wait;
        end
      end else if (m_cnt != 0) begin
        if (m_cnt == 1) begin
          if (m_we) mem[m_addr[10:1]] <= wr_merge(mem[m_addr[10:1]], m_din, m_wtbt, m_addr[0]);
          else      sd_dout <= rd_data(mem[m_addr[10:1]], m_wtbt, m_addr[0]);
          sd_ready <= 1'b1;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [24:0] s_addr;
  logic [15:0] s_din;
  logic [1:0]  s_wtbt;
  logic        s_we, s_rd;

  // One access: request held until ack, dropped one cycle after ack.
  // cyc counts clock edges from request to the edge that raised ack.
  task automatic access(input string tag, input bit pb, input bit we,
                        input logic [24:0] addr, input logic [15:0] din,
                        input logic [1:0] wt, output int cyc);
    bit seen, got;
    if (pb) begin
      b_we = we; b_addr = addr; b_din = din; b_wtbt = wt; b_req = 1'b1;
    end else begin
      a_we = we; a_addr = addr; a_din = din[7:0]; a_req = 1'b1;
    end
    cyc = 0; seen = 0; got = 0;
    while (!got && cyc < 2000) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (!seen && (sd_we || sd_rd)) begin
        s_addr = sd_addr; s_din = sd_din; s_wtbt = sd_wtbt; s_we = sd_we; s_rd = sd_rd;
        seen = 1;
      end
      got = pb ? b_ack : a_ack;
    end
    chk({tag, "_ack"}, {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    if (pb) b_req = 1'b0; else a_req = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int  cyc, cnt, low_cnt, bad_ack, bad_strb;
  bit  busy;

  initial begin
    init_n = 1'b0; m_clear = 1'b1; m_wait = 2;
    a_req = 0; a_we = 0; a_addr = '0; a_din = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_din = '0; b_wtbt = '0;
    repeat (2) @(posedge clk);
    #1 m_clear = 1'b0;
    @(negedge clk);
    chk("rst_ctl",  {28'd0, sd_we, sd_rd, a_ack, b_ack}, 32'd0);
    chk("rst_dout", {8'd0, a_dout, b_dout}, 32'd0);
    chk("rst_addr", {7'd0, sd_addr}, 32'd0);
    chk("rst_din",  {14'd0, sd_wtbt, sd_din}, 32'd0);
    @(posedge clk); #1 init_n = 1'b1;

    // A byte write, then B word read of the same word.
    access("a_wr", 0, 1, 25'h0000123, 16'h005A, 2'b00, cyc);
    chk("a_wr_strobe", {30'd0, s_we, s_rd}, 32'd2);
    chk("a_wr_din",    {16'd0, s_din}, 32'h5A5A);
    chk("a_wr_wtbt",   {30'd0, s_wtbt}, 32'd0);
    chk("a_wr_addr",   {7'd0, s_addr}, 32'h123);
    chk("a_wr_lat",    cyc, 32'd5);
    chk("a_wr_dout",   {24'd0, a_dout}, 32'd0);
    access("b_rd", 1, 0, 25'h0000122, 16'h0000, 2'b00, cyc);
    chk("b_rd_hi",   {24'd0, b_dout[15:8]}, 32'h5A);
    chk("b_rd_word", {16'd0, b_dout}, 32'h5A00);
    chk("b_rd_wtbt", {30'd0, s_wtbt}, 32'd3);

    // B write with empty byte enables on an odd address.
    access("b_wr", 1, 1, 25'h0000201, 16'hBEEF, 2'b00, cyc);
    chk("b_wr_addr", {7'd0, s_addr}, 32'h200);
    chk("b_wr_wtbt", {30'd0, s_wtbt}, 32'd3);
    chk("b_wr_dout", {16'd0, b_dout}, 32'h5A00);
    access("b_rd2", 1, 0, 25'h0000200, 16'h0000, 2'b00, cyc);
    chk("b_rd2_word", {16'd0, b_dout}, 32'hBEEF);

    // Two A reads of the same word with sd_ready never dropping.
    access("b_wr2", 1, 1, 25'h0000010, 16'h3412, 2'b11, cyc);
    m_wait = 0;
    access("a_rd0", 0, 0, 25'h0000010, 16'h0000, 2'b00, cyc);
    chk("a_rd0_lat",  cyc, 32'd3);
    chk("a_rd0_dout", {24'd0, a_dout}, 32'h12);
    access("a_rd1", 0, 0, 25'h0000011, 16'h0000, 2'b00, cyc);
    chk("a_rd1_lat",  cyc, 32'd3);
    chk("a_rd1_dout", {24'd0, a_dout}, 32'h34);
    chk("a_rd1_bkeep", {16'd0, b_dout}, 32'h3412 ^ 32'h3412 ^ 32'hBEEF);

    // Long stall in WAIT.
    m_wait = 700; busy = 1; low_cnt = 0; bad_ack = 0; bad_strb = 0;
    fork
      begin
        access("stall", 0, 0, 25'h0000010, 16'h0000, 2'b00, cyc);
        busy = 0;
      end
      begin
        while (busy) begin
          @(negedge clk);
          if (!sd_ready) begin
            low_cnt++;
            if (a_ack || b_ack) bad_ack++;
            if (!sd_rd) bad_strb++;
          end
        end
      end
    join
    chk("stall_lat",   cyc, 32'd703);
    chk("stall_low",   low_cnt, 32'd700);
    chk("stall_noack", bad_ack, 32'd0);
    chk("stall_strb",  bad_strb, 32'd0);
    chk("stall_dout",  {24'd0, a_dout}, 32'h12);

    // Simultaneous held requests: fixed priority vs round-robin.
    @(posedge clk); #1 init_n = 1'b0;
    @(posedge clk); #1 init_n = 1'b1;
    m_wait = 0;
    a_we = 0; a_addr = 25'h10; b_we = 0; b_addr = 25'h200;
    a_req = 1; b_req = 1;
    for (int i = 0; i < 4; i++) begin
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!(a_ack || b_ack) && cnt < 100);
      chk($sformatf("pri_grant%0d", i), {30'd0, a_ack, b_ack}, 32'd2);
      chk($sformatf("rr_grant%0d", i), {30'd0, rr_a_ack, rr_b_ack},
          ((i % 2) == 0) ? 32'd2 : 32'd1);
    end
    a_req = 0; b_req = 0;
    repeat (3) @(posedge clk);

    // Reset during GUARD, then the held B request resumes.
    m_wait = 2;
    #1 b_we = 0; b_addr = 25'h200; b_req = 1;
    @(posedge clk); #1;
    chk("guard_rd", {31'd0, sd_rd}, 32'd1);
    #2 init_n = 1'b0;
    #1;
    chk("rst_async_rd",  {31'd0, sd_rd}, 32'd0);
    chk("rst_async_ack", {30'd0, a_ack, b_ack}, 32'd0);
    @(posedge clk); #1 init_n = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!b_ack && cnt < 100);
    chk("resume_ack",  {31'd0, b_ack}, 32'd1);
    chk("resume_lat",  cnt, 32'd6);
    chk("resume_dout", {16'd0, b_dout}, 32'hBEEF);
    @(posedge clk); #1 b_req = 0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter A_PRIORITY, default 1, meaning 1 = port A always wins simultaneous requests and 0 = round-robin between A and B.
REQ-002 SHALL have port clk, input, 1, the single clock (~100 MHz), shared with the SDRAM controller.
REQ-003 SHALL have port init_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port A (CPU, 8-bit) inputs a_req (1), a_we (1), a_addr (25), a_din (8), and outputs a_dout (8), a_ack (1).
REQ-005 SHALL have port B (DMA/loader, 16-bit) inputs b_req (1), b_we (1), b_addr (25), b_din (16), b_wtbt (2), and outputs b_dout (16), b_ack (1).
REQ-006 SHALL have controller-side outputs sd_addr (25), sd_din (16), sd_wtbt (2), sd_we (1), sd_rd (1), and inputs sd_dout (16), sd_ready (1).

Function
REQ-007 Requesters SHALL hold x_req with stable x_we/x_addr/x_din until x_ack, a one-cycle pulse; x_req low in the ack cycle or the next SHALL NOT start a new access.
REQ-008 States SHALL be IDLE, GUARD, WAIT.
REQ-009 IDLE: if sd_ready=1 and a request is pending, grant one port, register sd_addr/sd_din/sd_wtbt, assert sd_we (write) or sd_rd (read), go to GUARD.
REQ-010 Arbitration SHALL be fixed A-first if A_PRIORITY=1; if 0, on a simultaneous request the port not granted last wins; a lone request always wins.
REQ-011 GUARD SHALL last exactly one cycle and ignore sd_ready, since the controller samples the strobe edge one cycle late.
REQ-012 WAIT: on sd_ready=1, capture the read data, deassert sd_we/sd_rd, pulse the granted x_ack for one cycle, go to IDLE.
REQ-013 Strobes SHALL be low for at least one full cycle between accesses, so each access is a fresh rising edge.
REQ-014 Port A: sd_addr=a_addr, sd_wtbt=2'b00 (8-bit mode), sd_din={a_din,a_din}, a_dout<=sd_dout[7:0].
REQ-015 Port B: sd_addr={b_addr[24:1],1'b0}, sd_din=b_din, sd_wtbt=b_wtbt on write (2'b00 promoted to 2'b11) and 2'b11 on read, b_dout<=sd_dout.
REQ-016 x_dout SHALL hold its value until the next read on the same port; writes leave x_dout unchanged.
REQ-017 A read that repeats the previous read word completes with sd_ready held high and SHALL still take exactly grant+2 cycles to ack.
REQ-018 Minimum latency SHALL be: grant at edge G, ack asserted after edge G+2; read data is valid in the same cycle as ack.
REQ-019 There SHALL be no timeout; WAIT persists until sd_ready=1 (controller refresh or startup simply stretches the wait).
REQ-020 A request arriving while the other port is being serviced SHALL be held and served on the next IDLE; x_req dropping before ack is a protocol violation and the access still completes.

Reset
REQ-021 init_n low SHALL asynchronously force state IDLE, sd_we=0, sd_rd=0, a_ack=0, b_ack=0, a_dout=0, b_dout=0, sd_addr=0, sd_din=0, sd_wtbt=0, and round-robin last-grant=B (so A wins first).
REQ-022 Reset mid-access SHALL drop strobes immediately and issue no ack; the controller is re-initialised by its own init.

Verification
REQ-023 A write a_addr=0x0000123, a_din=0x5A -> sd_we rises with sd_wtbt=00 and sd_din=0x5A5A; a_ack 1 cycle after sd_ready=1; B read at 0x0000122 -> b_dout[15:8]=0x5A.
REQ-024 Simultaneous a_req/b_req with A_PRIORITY=0 over 4 back-to-back requests -> grants alternate A,B,A,B; with A_PRIORITY=1 -> A,A,A,A while A is held.
REQ-025 Two A reads at 0x0000010 then 0x0000011 (same word, sd_ready never drops) -> both ack at grant+2; a_dout shows byte 0 then byte 1.
REQ-026 B write b_wtbt=00, b_din=0xBEEF, b_addr=0x0000201 -> sd_addr=0x0000200, sd_wtbt=11; subsequent read returns 0xBEEF.
REQ-027 sd_ready held low for 700 cycles (refresh/startup) during WAIT -> no ack, strobe stays high, ack follows sd_ready=1 by one cycle.
REQ-028 init_n pulsed low during GUARD -> sd_rd=0 asynchronously, no ack; after release, a pending b_req is served normally.
